// File: rtl/uart_transmitter.sv
// UART transmitter, 8N1, LSB first. A one-deep holding register lets the next
// byte wait while the current frame is shifted out, so chained frames have no gap.
module uart_transmitter #(
  parameter int CLKs_Per_Bit = 87
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_DV,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_tx_active,
  output logic       o_tx_serial,
  output logic       o_tx_done
);

  localparam int              CntW    = $clog2(CLKs_Per_Bit) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKs_Per_Bit - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      buf_q, buf_d;
  logic            buf_valid_q, buf_valid_d;
  logic            ready_q, ready_d;
  logic            active_q, active_d;
  logic            serial_q, serial_d;
  logic            done_q, done_d;
  logic            accept_s, load_s, bit_end_s;

  // Next-state, holding-register and registered-output logic
  always_comb begin
    accept_s  = i_tx_DV && ready_q;
    bit_end_s = (cnt_q == CntLast);
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    load_s    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = 3'd0;
        if (buf_valid_q) begin
          load_s  = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_d  = '0;
          done_d = 1'b1;
          // Chain straight into the next start bit when a byte is waiting
          if (buf_valid_q) begin
            load_s  = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        cnt_d   = '0;
        idx_d   = 3'd0;
        state_d = IDLE;
      end
    endcase

    if (load_s) begin
      shift_d = buf_q;
    end else begin
      shift_d = shift_q;
    end

    // accept_s needs an empty buffer and load_s a full one, so they never collide
    if (accept_s) begin
      buf_valid_d = 1'b1;
      buf_d       = i_tx_byte;
    end else if (load_s) begin
      buf_valid_d = 1'b0;
      buf_d       = buf_q;
    end else begin
      buf_valid_d = buf_valid_q;
      buf_d       = buf_q;
    end
    ready_d = ~buf_valid_d;

    case (state_d)
      IDLE:    serial_d = 1'b1;
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[idx_d];
      STOP:    serial_d = 1'b1;
      default: serial_d = 1'b1;
    endcase
    active_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      buf_q       <= 8'h00;
      buf_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      active_q    <= 1'b0;
      serial_q    <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      ready_q     <= ready_d;
      active_q    <= active_d;
      serial_q    <= serial_d;
      done_q      <= done_d;
    end
  end

  assign o_tx_ready  = ready_q;
  assign o_tx_active = active_q;
  assign o_tx_serial = serial_q;
  assign o_tx_done   = done_q;

endmodule
